alu_scheduler: RTL and testbench
================================

# alu_scheduler

Sequencer and two-port arbiter for the shared 8-bit ALU in the MiniCPU datapath. Two requesters, such as the fetch unit's PC increment and the execute stage, submit operations over valid/ready handshakes. The block grants one requester at a time in round-robin order, drives the ALU operand buses, and selects the ALU output for the requested op. It also builds an 8-cycle MUL from the shared adder and returns a registered, flagged result over a valid/ready response channel.

## Interface
Parameters:
- MUL_EN, default 1: 1 enables opcode 8 (MUL); 0 treats it as illegal.

Ports (name, direction, width, meaning):
- CLK, in, 1: the single clock. All state changes on the rising edge.
- RST_N, in, 1: synchronous, active-low reset.
- REQ0_VALID, in, 1: requester 0 has an op pending.
- REQ0_READY, out, 1: requester 0 is granted this cycle.
- REQ0_OP, in, 4: opcode.
- REQ0_A, in, 8: operand A.
- REQ0_B, in, 8: operand B.
- REQ1_VALID, REQ1_READY, REQ1_OP, REQ1_A, REQ1_B: same as requester 0, for requester 1.
- ALU_A, out, 8: registered operand to the ALU A input.
- ALU_B, out, 8: registered operand to the ALU B input.
- ALU_ADD, ALU_SL, ALU_SR, ALU_AND, ALU_OR, ALU_XOR, ALU_NAND, ALU_COMP, in, 8 each: the ALU result buses.
- RSP_VALID, out, 1: response available.
- RSP_READY, in, 1: consumer accepts the response.
- RSP_ID, out, 1: which requester the response belongs to.
- RSP_DATA, out, 8: result.
- RSP_ZERO, out, 1: RSP_DATA == 0.
- RSP_ERR, out, 1: illegal opcode.
- BUSY, out, 1: state is not IDLE.

## Operation
- Opcodes: 0 ADD, 1 SL, 2 SR, 3 AND, 4 OR, 5 XOR, 6 NAND, 7 CMP, 8 MUL (only when MUL_EN=1). 9–15 are illegal.
- FSM states are IDLE, EXEC, MUL, RESP.
- IDLE:
  - A request is accepted when a requester has VALID high and is granted (READY high).
  - On accept, latch the opcode and requester ID, and load ALU_A and ALU_B with the operands.
  - Next state is EXEC for opcodes 0–7 and MUL for opcode 8.
  - For an illegal opcode, go straight to RESP with RSP_DATA=0, RSP_ERR=1, RSP_ZERO=1.
- EXEC: RSP_DATA takes the ALU bus selected by the opcode, RSP_ZERO is computed, RSP_ERR=0. Next state is RESP.
- MUL (shift-add, low 8 bits of the product, 8 iterations):
  - Registers: acc, m, q, step counter.
  - On accept: acc=0, m=A, q=B, ALU_A=0, ALU_B = B[0] ? A : 0.
  - Each MUL cycle:
    - acc ← ALU_ADD.
    - m ← m<<1 and q ← q>>1, both internal, not through the ALU.
    - ALU_A ← ALU_ADD and ALU_B ← next q[0] ? next m : 0.
  - After step 8 (counter 7→0), RSP_DATA ← ALU_ADD and next state is RESP.
- RESP: RSP_VALID=1, and RSP_ID, RSP_DATA, RSP_ZERO, RSP_ERR are held stable. On RSP_VALID & RSP_READY, go to IDLE.
- Arbitration:
  - Round-robin between the two requesters. The LAST_GRANT register resets to 1, so requester 0 wins the first tie.
  - If only one requester is valid, it is granted.
  - LAST_GRANT updates only on accept.
- READY rules:
  - REQx_READY is combinational from state, LAST_GRANT and the two VALIDs. It is high only in IDLE, only for the granted requester, and only when that requester's VALID is high.
  - The two READYs are never high together.
- Arithmetic:
  - All arithmetic is modulo 256; the ADD carry is discarded.
  - ALU_COMP is passed through unmodified.

## Timing
- Reset (RST_N=0 at an edge) forces:
  - state=IDLE, LAST_GRANT=1.
  - ALU_A=0, ALU_B=0.
  - RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_ZERO=0, RSP_ERR=0, BUSY=0.
  - REQ0_READY=0 and REQ1_READY=0 while RST_N is low.
- Reset mid-operation (EXEC, MUL or RESP) discards the op with no response.
- Latency, counting the accept edge as cycle N:
  - ALU ops: RSP_VALID high from cycle N+2.
  - MUL: RSP_VALID high from cycle N+9.
  - Illegal opcode: RSP_VALID high from cycle N+1.
- Throughput with RSP_READY held high: one ALU op every 3 cycles. There is no bypass from RESP to a new accept.
- Backpressure: RESP holds indefinitely. Requests wait with READY=0, and requesters must keep VALID, OP, A and B stable until READY.
- When both requesters are valid continuously, grants alternate 0,1,0,1…

## Structure
- Package minicpu_alu_pkg holds:
  - opcode constants OP_ADD … OP_MUL;
  - the state enum {IDLE, EXEC, MUL, RESP};
  - DATA_W=8 and MUL_STEPS=8.
- Sub-module rr_arbiter2 is a 2-way round-robin arbiter. It takes VALID[1:0] and an accept strobe, and outputs a one-hot GRANT[1:0] and the LAST_GRANT register.
- The ALU itself is instantiated at the parent as a sibling block, not inside alu_scheduler.

## Test plan
- Reset, then REQ0 ADD with A=0xF0, B=0x20 → RSP_VALID at N+2 with RSP_DATA=0x10, RSP_ZERO=0, RSP_ID=0.
- REQ1 MUL with A=13, B=11 → RSP_VALID at N+9 with RSP_DATA=0x8F. Then MUL with A=16, B=16 → RSP_DATA=0x00, RSP_ZERO=1.
- Both requesters hold XOR continuously → grant order 0,1,0,1, and each READY pulses for exactly one cycle.
- Illegal opcode 12 → RSP_VALID at N+1 with RSP_ERR=1, RSP_DATA=0, RSP_ZERO=1.
- RSP_READY low for 5 cycles → response held stable, REQx_READY stays 0, and accept occurs on the cycle after the RSP handshake.
- RST_N low during MUL step 4 → next cycle IDLE with BUSY=0 and RSP_VALID=0, no response is ever issued, and the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/alu_scheduler_pkg.sv
// Shared constants and types for the MiniCPU ALU scheduler.
package minicpu_alu_pkg;
  localparam int DATA_W    = 8;
  localparam int MUL_STEPS = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SL   = 4'd1;
  localparam logic [3:0] OP_SR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  function automatic logic op_legal(input logic [3:0] op, input bit mul_en);
    return (op < OP_MUL) || (mul_en && (op == OP_MUL));
  endfunction
endpackage

// File: rtl/alu_scheduler_if.sv
// Request, ALU and response buses between the requesters/ALU and the scheduler.
interface alu_scheduler_if;
  import minicpu_alu_pkg::*;

  logic              req0_valid, req0_ready;
  logic [3:0]        req0_op;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req1_a, req1_b;

  logic [DATA_W-1:0] alu_a, alu_b;
  logic [DATA_W-1:0] alu_add, alu_sl, alu_sr, alu_and, alu_or, alu_xor, alu_nand, alu_comp;

  logic              rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, input req0_ready,
    output req1_valid, req1_op, req1_a, req1_b, input req1_ready,
    input  alu_a, alu_b,
    output alu_add, alu_sl, alu_sr, alu_and, alu_or, alu_xor, alu_nand, alu_comp,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, output req1_ready,
    output alu_a, alu_b,
    input  alu_add, alu_sl, alu_sr, alu_and, alu_or, alu_xor, alu_nand, alu_comp,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_scheduler_arb.sv
// Two-way round-robin arbiter; last_grant names the requester that won the last accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       last_grant
);
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant[1];
  end
endmodule

// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto the shared ALU, sequences shift-add MUL,
// and returns a registered, flagged result over a valid/ready response.
module alu_scheduler #(
  parameter bit MUL_EN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  alu_scheduler_if.slave bus
);
  import minicpu_alu_pkg::*;

  localparam int CNT_W = $clog2(MUL_STEPS);

  state_t            state_reg, state_next;
  logic [3:0]        op_reg, op_next;
  logic [DATA_W-1:0] alu_a_reg, alu_a_next, alu_b_reg, alu_b_next;
  logic [DATA_W-1:0] m_reg, m_next, q_reg, q_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              rsp_id_reg, rsp_id_next, rsp_zero_reg, rsp_zero_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;

  logic [1:0]        valid, grant, ready;
  logic              idle, accept, last_grant;
  logic [3:0]        op_in;
  logic [DATA_W-1:0] a_in, b_in, exec_result, m_shift, q_shift;

  assign valid  = {bus.req1_valid, bus.req0_valid};
  assign idle   = (state_reg == IDLE) && rst_n;
  assign accept = |ready;

  rr_arbiter2 u_arb (
    .clk(clk), .rst_n(rst_n), .valid(valid), .accept(accept),
    .grant(grant), .last_grant(last_grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready[gi] = grant[gi] & idle;
    end
  endgenerate

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];

  assign op_in   = grant[1] ? bus.req1_op : bus.req0_op;
  assign a_in    = grant[1] ? bus.req1_a  : bus.req0_a;
  assign b_in    = grant[1] ? bus.req1_b  : bus.req0_b;
  assign m_shift = m_reg << 1;
  assign q_shift = q_reg >> 1;

  always_comb begin
    exec_result = '0;
    case (op_reg)
      OP_ADD:  exec_result = bus.alu_add;
      OP_SL:   exec_result = bus.alu_sl;
      OP_SR:   exec_result = bus.alu_sr;
      OP_AND:  exec_result = bus.alu_and;
      OP_OR:   exec_result = bus.alu_or;
      OP_XOR:  exec_result = bus.alu_xor;
      OP_NAND: exec_result = bus.alu_nand;
      OP_CMP:  exec_result = bus.alu_comp;
      default: exec_result = '0;
    endcase
  end

  // The ALU A register doubles as the MUL accumulator: it always holds the running sum.
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    alu_a_next    = alu_a_reg;
    alu_b_next    = alu_b_reg;
    m_next        = m_reg;
    q_next        = q_reg;
    cnt_next      = cnt_reg;
    rsp_id_next   = rsp_id_reg;
    rsp_data_next = rsp_data_reg;
    rsp_zero_next = rsp_zero_reg;
    rsp_err_next  = rsp_err_reg;
    case (state_reg)
      IDLE: if (accept) begin
        op_next     = op_in;
        rsp_id_next = grant[1];
        alu_a_next  = a_in;
        alu_b_next  = b_in;
        m_next      = a_in;
        q_next      = b_in;
        cnt_next    = CNT_W'(MUL_STEPS - 1);
        if (!op_legal(op_in, MUL_EN)) begin
          rsp_data_next = '0;
          rsp_zero_next = 1'b1;
          rsp_err_next  = 1'b1;
          state_next    = RESP;
        end else if (op_in == OP_MUL) begin
          alu_a_next = '0;
          alu_b_next = b_in[0] ? a_in : '0;
          state_next = MUL;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        rsp_data_next = exec_result;
        rsp_zero_next = (exec_result == '0);
        rsp_err_next  = 1'b0;
        state_next    = RESP;
      end
      MUL: begin
        alu_a_next = bus.alu_add;
        m_next     = m_shift;
        q_next     = q_shift;
        alu_b_next = q_shift[0] ? m_shift : '0;
        cnt_next   = cnt_reg - CNT_W'(1);
        if (cnt_reg == '0) begin
          rsp_data_next = bus.alu_add;
          rsp_zero_next = (bus.alu_add == '0);
          rsp_err_next  = 1'b0;
          state_next    = RESP;
        end
      end
      RESP: if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      m_reg        <= '0;
      q_reg        <= '0;
      cnt_reg      <= '0;
      rsp_id_reg   <= 1'b0;
      rsp_data_reg <= '0;
      rsp_zero_reg <= 1'b0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      alu_a_reg    <= alu_a_next;
      alu_b_reg    <= alu_b_next;
      m_reg        <= m_next;
      q_reg        <= q_next;
      cnt_reg      <= cnt_next;
      rsp_id_reg   <= rsp_id_next;
      rsp_data_reg <= rsp_data_next;
      rsp_zero_reg <= rsp_zero_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_zero  = rsp_zero_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench: directed vector table, arbitration/backpressure/reset sequences,
// and randomized ops against an arithmetic reference model.
module tb_alu_scheduler;
  import minicpu_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   last_grant_model = 1;

  alu_scheduler_if bus();

  alu_scheduler #(.MUL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural stand-in for the sibling ALU.
  assign bus.alu_add  = bus.alu_a + bus.alu_b;
  assign bus.alu_sl   = bus.alu_a << bus.alu_b[2:0];
  assign bus.alu_sr   = bus.alu_a >> bus.alu_b[2:0];
  assign bus.alu_and  = bus.alu_a & bus.alu_b;
  assign bus.alu_or   = bus.alu_a | bus.alu_b;
  assign bus.alu_xor  = bus.alu_a ^ bus.alu_b;
  assign bus.alu_nand = ~(bus.alu_a & bus.alu_b);
  assign bus.alu_comp = {6'b0, bus.alu_a == bus.alu_b, bus.alu_a < bus.alu_b};

  typedef struct {
    logic [3:0] op;
    int         id;
    logic [7:0] a, b, data;
    logic       zero, err;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id == 1) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  function automatic void ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] data, output logic zero,
                                    output logic err, output int lat);
    int ia, ib, sh, r;
    ia = a; ib = b; sh = ib % 8;
    err = 1'b0; lat = 2;
    case (op)
      4'd0: r = ia + ib;
      4'd1: r = ia * (1 << sh);
      4'd2: r = ia / (1 << sh);
      4'd3: r = ia & ib;
      4'd4: r = ia | ib;
      4'd5: r = ia ^ ib;
      4'd6: r = 255 - (ia & ib);
      4'd7: r = ((ia == ib) ? 2 : 0) + ((ia < ib) ? 1 : 0);
      4'd8: begin r = ia * ib; lat = 9; end
      default: begin r = 0; err = 1'b1; lat = 1; end
    endcase
    data = 8'(r % 256);
    zero = (data == 8'd0);
  endfunction

  // Entered just after a negedge; returns with rsp_valid high or the bound expired.
  task automatic wait_rsp(input string name, output int lat);
    lat = 1;
    #1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    check({name, " rsp_timeout"}, bus.rsp_valid, 1);
  endtask

  task automatic run_op(input string name, input int id, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] e_data,
                        input logic e_zero, input logic e_err, input int e_lat);
    int lat;
    bus.rsp_ready = 1'b0;
    set_req(id, 1'b1, op, a, b);
    #1;
    check({name, " ready"}, (id == 1) ? bus.req1_ready : bus.req0_ready, 1);
    check({name, " other_ready"}, (id == 1) ? bus.req0_ready : bus.req1_ready, 0);
    @(negedge clk);
    set_req(id, 1'b0, 4'd0, 8'd0, 8'd0);
    wait_rsp(name, lat);
    check({name, " latency"}, lat, e_lat);
    check({name, " data"}, bus.rsp_data, e_data);
    check({name, " zero"}, bus.rsp_zero, e_zero);
    check({name, " err"}, bus.rsp_err, e_err);
    check({name, " id"}, bus.rsp_id, id);
    $display("%s: id=%0d op=%0d a=%02h b=%02h -> data=%02h zero=%0b err=%0b lat=%0d",
             name, id, op, a, b, bus.rsp_data, bus.rsp_zero, bus.rsp_err, lat);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check({name, " busy_after"}, bus.busy, 0);
    last_grant_model = id;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ngr, cyc, prev_cyc, expect_id, g, rsp_seen;
    int exp_q[$];
    logic [7:0] held, e_data;
    logic e_zero, e_err;
    logic [3:0] op;

    vecs[0]  = '{4'd0,  0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 2};
    vecs[1]  = '{4'd8,  1, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 9};
    vecs[2]  = '{4'd8,  0, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 9};
    vecs[3]  = '{4'd12, 1, 8'h55, 8'hAA, 8'h00, 1'b1, 1'b1, 1};
    vecs[4]  = '{4'd1,  0, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 2};
    vecs[5]  = '{4'd2,  1, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0, 2};
    vecs[6]  = '{4'd3,  0, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 2};
    vecs[7]  = '{4'd4,  1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 2};
    vecs[8]  = '{4'd6,  0, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 2};
    vecs[9]  = '{4'd7,  1, 8'h05, 8'h09, 8'h01, 1'b0, 1'b0, 2};
    vecs[10] = '{4'd8,  0, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 9};
    vecs[11] = '{4'd0,  1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 2};
    vecs[12] = '{4'd9,  0, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 1};
    vecs[13] = '{4'd15, 1, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 1};

    // Reset with both requesters already valid.
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'd0, 8'h11, 8'h22);
    set_req(1, 1'b1, 4'd0, 8'h33, 8'h44);
    repeat (3) @(negedge clk);
    #1;
    check("reset req0_ready", bus.req0_ready, 0);
    check("reset req1_ready", bus.req1_ready, 0);
    check("reset busy", bus.busy, 0);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset alu_a", bus.alu_a, 0);
    check("reset alu_b", bus.alu_b, 0);
    check("reset rsp_data", bus.rsp_data, 0);
    check("reset rsp_id", bus.rsp_id, 0);
    check("reset rsp_zero", bus.rsp_zero, 0);
    check("reset rsp_err", bus.rsp_err, 0);
    @(negedge clk);
    set_req(0, 1'b0, 4'd0, 8'd0, 8'd0);
    set_req(1, 1'b0, 4'd0, 8'd0, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].data, vecs[i].zero, vecs[i].err, vecs[i].lat);

    // Both requesters hold XOR: grants must alternate, spaced 3 cycles apart.
    @(negedge clk);
    expect_id = 1 - last_grant_model;
    prev_cyc = -1; ngr = 0; cyc = 0;
    set_req(0, 1'b1, 4'd5, 8'h5A, 8'h0F);
    set_req(1, 1'b1, 4'd5, 8'h33, 8'hFF);
    bus.rsp_ready = 1'b1;
    while (ngr < 8 && cyc < 60) begin
      #1;
      check("rr both_ready", bus.req0_ready & bus.req1_ready, 0);
      if (bus.rsp_valid && exp_q.size() > 0) begin
        g = exp_q.pop_front();
        check("rr rsp_id", bus.rsp_id, g);
        check("rr rsp_data", bus.rsp_data, (g == 1) ? 8'hCC : 8'h55);
        $display("rr rsp: id=%0d data=%02h", bus.rsp_id, bus.rsp_data);
      end
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready ? 1 : 0;
        check("rr grant_order", g, expect_id);
        if (prev_cyc >= 0) check("rr grant_spacing", cyc - prev_cyc, 3);
        prev_cyc = cyc;
        exp_q.push_back(expect_id);
        last_grant_model = expect_id;
        expect_id = 1 - expect_id;
        ngr++;
      end
      @(negedge clk);
      cyc++;
    end
    set_req(0, 1'b0, 4'd0, 8'd0, 8'd0);
    set_req(1, 1'b0, 4'd0, 8'd0, 8'd0);
    check("rr grant_count", ngr, 8);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      #1;
      if (bus.rsp_valid) begin
        g = exp_q.pop_front();
        check("rr drain_id", bus.rsp_id, g);
        check("rr drain_data", bus.rsp_data, (g == 1) ? 8'hCC : 8'h55);
        $display("rr rsp: id=%0d data=%02h", bus.rsp_id, bus.rsp_data);
      end
      @(negedge clk);
    end
    check("rr drained", exp_q.size(), 0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    // Backpressure: response held 5 cycles while requester 1 waits.
    set_req(0, 1'b1, 4'd0, 8'h12, 8'h34);
    #1;
    check("bp req0_ready", bus.req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 4'd0, 8'd0, 8'd0);
    set_req(1, 1'b1, 4'd4, 8'hA0, 8'h0F);
    wait_rsp("bp first", lat);
    held = bus.rsp_data;
    check("bp first_data", held, 8'h46);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("bp hold_valid", bus.rsp_valid, 1);
      check("bp hold_data", bus.rsp_data, 8'h46);
      check("bp hold_id", bus.rsp_id, 0);
      check("bp req1_blocked", bus.req1_ready, 0);
    end
    $display("bp: response id=0 data=%02h held 5 cycles", bus.rsp_data);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    check("bp no_bypass", bus.req1_ready, 0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("bp accept_after", bus.req1_ready, 1);
    @(negedge clk);
    set_req(1, 1'b0, 4'd0, 8'd0, 8'd0);
    wait_rsp("bp second", lat);
    check("bp second_lat", lat, 2);
    check("bp second_data", bus.rsp_data, 8'hAF);
    check("bp second_id", bus.rsp_id, 1);
    $display("bp: response id=1 data=%02h", bus.rsp_data);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    last_grant_model = 1;

    // Reset during MUL step 4 discards the op; first grant afterwards goes to requester 0.
    set_req(1, 1'b1, 4'd8, 8'd200, 8'd3);
    #1;
    check("rst req1_ready", bus.req1_ready, 1);
    @(negedge clk);
    set_req(1, 1'b0, 4'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 4'd0, 8'h01, 8'h02);
    set_req(1, 1'b1, 4'd0, 8'h10, 8'h20);
    #1;
    check("rst busy", bus.busy, 0);
    check("rst rsp_valid", bus.rsp_valid, 0);
    check("rst ready0_low", bus.req0_ready, 0);
    check("rst ready1_low", bus.req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst first_grant0", bus.req0_ready, 1);
    check("rst first_grant1", bus.req1_ready, 0);
    @(negedge clk);
    set_req(0, 1'b0, 4'd0, 8'd0, 8'd0);
    set_req(1, 1'b0, 4'd0, 8'd0, 8'd0);
    wait_rsp("rst add", lat);
    check("rst add_lat", lat, 2);
    check("rst add_id", bus.rsp_id, 0);
    check("rst add_data", bus.rsp_data, 8'h03);
    $display("rst: response id=%0d data=%02h", bus.rsp_id, bus.rsp_data);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rsp_seen = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (bus.rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    check("rst no_stale_rsp", rsp_seen, 0);
    last_grant_model = 0;

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      int id;
      logic [7:0] a, b;
      id = $urandom_range(0, 1);
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = OP_MUL;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      ref_model(op, a, b, e_data, e_zero, e_err, lat);
      run_op($sformatf("rand%0d", i), id, op, a, b, e_data, e_zero, e_err, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
